reaction_timer_fsm: RTL and testbench



---
 rtl/reaction_timer_fsm.sv | 188 ++++++++++++++++++
 tb/tb_reaction_timer_fsm.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_fsm.sv
// Multi-round reaction-time game controller: random hold-off, ms timing, false-start and best-time tracking.
// Define AVG_EN to add avg_ms, the mean of the game's results, presented in FINAL.
module reaction_timer_fsm #(
   parameter int          LED_W        = 10,
   parameter int          TIME_W       = 12,
   parameter int          ROUNDS       = 4,
   parameter int          MIN_DELAY_MS = 1000,
   parameter int          DLY_RAND_W   = 10,
   parameter int          MAX_MS       = 4000,
   parameter logic [15:0] SEED         = 16'hACE1
) (
   input  logic                         clk,
   input  logic                         Reset,
   input  logic                         start,
   input  logic                         tick,
   output logic [LED_W-1:0]             LED,
   output logic                         en_dc,
   output logic                         en_c,
   output logic [TIME_W-1:0]            reaction_ms,
   output logic [TIME_W-1:0]            best_ms,
   output logic [$clog2(ROUNDS+1)-1:0]  round_idx,
   output logic                         result_valid,
   output logic                         false_start,
   output logic                         timeout,
`ifdef AVG_EN
   output logic [TIME_W-1:0]            avg_ms,
`endif
   output logic                         done
);

   // state    | meaning
   // S_IDLE   | waiting for the first press of a game
   // S_ARM    | hold-off delay counting down, LEDs dark
   // S_TIMING | LEDs lit, counting ms until the press
   // S_RESULT | round recorded, waiting for the next press
   // S_FOUL   | pressed during hold-off, waiting to re-arm
   // S_FINAL  | all rounds played, outputs frozen

   localparam int                 RW       = $clog2(ROUNDS+1);
   localparam logic [TIME_W-1:0]  MAX_T    = TIME_W'(MAX_MS);
   localparam logic [RW-1:0]      LAST_RND = RW'(ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE, S_ARM, S_TIMING, S_RESULT, S_FOUL, S_FINAL
   } state_t;

   state_t             state, state_n;
   logic               start_q, armed_q, press;
   logic [15:0]        lfsr, lfsr_n, lfsr_adv;
   logic [TIME_W-1:0]  dly, dly_n, cnt, cnt_n, dly_init;
   logic [TIME_W-1:0]  reaction_n, best_n;
   logic [RW-1:0]      round_n;
   logic               valid_n, timeout_n;
   logic [31:0]        dly_sum;

`ifdef AVG_EN
   localparam int AW = $clog2(ROUNDS);
   localparam int SW = TIME_W + AW;
   logic [SW-1:0] acc, acc_n;

   if ((1 << AW) != ROUNDS) begin : g_rounds_chk
      $error("reaction_timer_fsm: ROUNDS must be a power of two with AVG_EN");
   end

   assign avg_ms = (state == S_FINAL) ? TIME_W'(acc >> AW) : '0;
`endif

   // armed_q blocks a button still held through reset from counting as a press
   assign press    = start_q & ~start & armed_q;
   assign lfsr_adv = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
   assign dly_sum  = 32'(MIN_DELAY_MS) + 32'(lfsr[DLY_RAND_W-1:0]);
   assign dly_init = (dly_sum > 32'({TIME_W{1'b1}})) ? {TIME_W{1'b1}} : dly_sum[TIME_W-1:0];

   assign LED         = {LED_W{state == S_TIMING}};
   assign en_dc       = (state == S_ARM);
   assign en_c        = (state == S_TIMING);
   assign false_start = (state == S_FOUL);
   assign done        = (state == S_FINAL);

   always_comb begin
      state_n    = state;
      lfsr_n     = lfsr;
      dly_n      = dly;
      cnt_n      = cnt;
      reaction_n = reaction_ms;
      best_n     = best_ms;
      round_n    = round_idx;
      valid_n    = 1'b0;
      timeout_n  = timeout;
`ifdef AVG_EN
      acc_n      = acc;
`endif
      case (state)
         S_IDLE: begin
            if (press) begin
               dly_n   = dly_init;
               lfsr_n  = lfsr_adv;
               state_n = S_ARM;
            end
         end
         S_ARM: begin
            if (tick && dly != '0) dly_n = dly - TIME_W'(1);
            if (press) begin
               state_n = S_FOUL;
            end else if (dly_n == '0) begin
               cnt_n   = '0;
               state_n = S_TIMING;
            end
         end
         S_TIMING: begin
            if (tick) cnt_n = cnt + TIME_W'(1);
            if (press) begin
               reaction_n = cnt_n;
               valid_n    = 1'b1;
               round_n    = round_idx + RW'(1);
               state_n    = S_RESULT;
               if (cnt_n < best_ms) best_n = cnt_n;
`ifdef AVG_EN
               acc_n      = acc + SW'(cnt_n);
`endif
            end else if (cnt_n >= MAX_T) begin
               reaction_n = MAX_T;
               timeout_n  = 1'b1;
               valid_n    = 1'b1;
               round_n    = round_idx + RW'(1);
               state_n    = S_RESULT;
`ifdef AVG_EN
               acc_n      = acc + SW'(MAX_T);
`endif
            end
         end
         S_RESULT: begin
            if (round_idx == LAST_RND) begin
               state_n = S_FINAL;
            end else if (press) begin
               timeout_n = 1'b0;
               dly_n     = dly_init;
               lfsr_n    = lfsr_adv;
               state_n   = S_ARM;
            end
         end
         // re-arm draws from the LFSR without advancing it
         S_FOUL: begin
            if (press) begin
               dly_n   = dly_init;
               state_n = S_ARM;
            end
         end
         S_FINAL: state_n = S_FINAL;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state        <= S_IDLE;
         start_q      <= 1'b1;
         armed_q      <= start;
         lfsr         <= SEED;
         dly          <= '0;
         cnt          <= '0;
         reaction_ms  <= '0;
         best_ms      <= '1;
         round_idx    <= '0;
         result_valid <= 1'b0;
         timeout      <= 1'b0;
`ifdef AVG_EN
         acc          <= '0;
`endif
      end else begin
         state        <= state_n;
         start_q      <= start;
         armed_q      <= armed_q | start;
         lfsr         <= lfsr_n;
         dly          <= dly_n;
         cnt          <= cnt_n;
         reaction_ms  <= reaction_n;
         best_ms      <= best_n;
         round_idx    <= round_n;
         result_valid <= valid_n;
         timeout      <= timeout_n;
`ifdef AVG_EN
         acc          <= acc_n;
`endif
      end
   end

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Randomised self-checking bench for reaction_timer_fsm against a game-level reference model.
module tb_reaction_timer_fsm;
   localparam int          LED_W        = 10;
   localparam int          TIME_W       = 12;
   localparam int          ROUNDS       = 2;
   localparam int          MIN_DELAY_MS = 4;
   localparam int          DLY_RAND_W   = 2;
   localparam int          MAX_MS       = 20;
   localparam logic [15:0] SEED         = 16'hACE1;
   localparam int          RW           = $clog2(ROUNDS+1);

   logic clk = 1'b0;
   logic Reset, start, tick;
   logic [LED_W-1:0]  LED;
   logic              en_dc, en_c, result_valid, false_start, timeout, done;
   logic [TIME_W-1:0] reaction_ms, best_ms;
   logic [RW-1:0]     round_idx;
`ifdef AVG_EN
   logic [TIME_W-1:0] avg_ms;
`endif

   int checks = 0;
   int errors = 0;

   // game-level model
   logic [15:0] m_lfsr;
   int m_dly, m_round, m_best, m_react, m_sum;
   logic m_timeout;

   reaction_timer_fsm #(
      .LED_W(LED_W), .TIME_W(TIME_W), .ROUNDS(ROUNDS), .MIN_DELAY_MS(MIN_DELAY_MS),
      .DLY_RAND_W(DLY_RAND_W), .MAX_MS(MAX_MS), .SEED(SEED)
   ) dut (
      .clk(clk), .Reset(Reset), .start(start), .tick(tick), .LED(LED),
      .en_dc(en_dc), .en_c(en_c), .reaction_ms(reaction_ms), .best_ms(best_ms),
      .round_idx(round_idx), .result_valid(result_valid), .false_start(false_start),
      .timeout(timeout),
`ifdef AVG_EN
      .avg_ms(avg_ms),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      int x, fb;
      x  = int'(v);
      fb = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 1;
      return 16'((x >> 1) | (fb << 15));
   endfunction

   function automatic int exp_delay(input logic [15:0] v);
      int d;
      d = MIN_DELAY_MS + (int'(v) % (1 << DLY_RAND_W));
      if (d > (1 << TIME_W) - 1) d = (1 << TIME_W) - 1;
      return d;
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_tick();
      tick = 1'b1; cyc(1);
      tick = 1'b0; cyc(1);
   endtask

   task automatic test_reset(input string tag, input logic hold);
      Reset = 1'b1; start = ~hold; tick = 1'b0;
      cyc(1);
      Reset = 1'b0;
      m_lfsr = SEED; m_round = 0; m_best = (1 << TIME_W) - 1; m_react = 0; m_sum = 0; m_timeout = 1'b0;
      checks++;
      if ({LED, en_dc, en_c, result_valid, false_start, timeout, done} !== '0) begin
         errors++; $display("FAIL %s ctl: got %b required all zero", tag,
                            {LED, en_dc, en_c, result_valid, false_start, timeout, done});
      end
      checks++;
      if ({reaction_ms, best_ms, round_idx} !== {{TIME_W{1'b0}}, {TIME_W{1'b1}}, {RW{1'b0}}}) begin
         errors++; $display("FAIL %s regs: got react=%0d best=%0d round=%0d required 0/%0d/0",
                            tag, reaction_ms, best_ms, round_idx, (1 << TIME_W) - 1);
      end
   endtask

   task automatic go_arm(input logic from_foul, input string tag);
      m_dly = exp_delay(m_lfsr);
      if (!from_foul) m_lfsr = lfsr_step(m_lfsr);
      m_timeout = 1'b0;
      start = 1'b0; cyc(1);
      start = 1'b1; cyc(1);
      checks++;
      if ({en_dc, en_c, false_start, timeout, LED} !== {1'b1, 1'b0, 1'b0, 1'b0, {LED_W{1'b0}}}) begin
         errors++; $display("FAIL %s: got en_dc=%b en_c=%b fs=%b to=%b LED=%h required 1/0/0/0/0",
                            tag, en_dc, en_c, false_start, timeout, LED);
      end
      checks++;
      if (round_idx !== RW'(m_round)) begin
         errors++; $display("FAIL %s round: got %0d required %0d", tag, round_idx, m_round);
      end
   endtask

   task automatic go_timing(input string tag);
      repeat (m_dly - 1) pulse_tick();
      checks++;
      if ({en_dc, en_c} !== 2'b10) begin
         errors++; $display("FAIL %s early: after %0d ticks en_dc/en_c=%b required 10", tag, m_dly - 1, {en_dc, en_c});
      end
      pulse_tick();
      checks++;
      if ({en_dc, en_c, LED} !== {1'b0, 1'b1, {LED_W{1'b1}}}) begin
         errors++; $display("FAIL %s lit: after %0d ticks en_dc=%b en_c=%b LED=%h required 0/1/all ones",
                            tag, m_dly, en_dc, en_c, LED);
      end
   endtask

   task automatic foul(input int k, input string tag);
      repeat (k) pulse_tick();
      start = 1'b0; cyc(1);
      checks++;
      if ({false_start, en_dc, en_c, LED, result_valid} !== {1'b1, 1'b0, 1'b0, {LED_W{1'b0}}, 1'b0}) begin
         errors++; $display("FAIL %s state: got fs=%b en_dc=%b en_c=%b LED=%h rv=%b required 1/0/0/0/0",
                            tag, false_start, en_dc, en_c, LED, result_valid);
      end
      checks++;
      if ({reaction_ms, round_idx} !== {TIME_W'(m_react), RW'(m_round)}) begin
         errors++; $display("FAIL %s regs: got react=%0d round=%0d required %0d/%0d",
                            tag, reaction_ms, round_idx, m_react, m_round);
      end
      start = 1'b1; cyc(1);
   endtask

   task automatic react(input int n, input string tag);
      if (n < MAX_MS) begin
         repeat (n) pulse_tick();
         start = 1'b0; cyc(1);
         m_react = n;
         if (n < m_best) m_best = n;
      end else begin
         repeat (MAX_MS - 1) pulse_tick();
         checks++;
         if ({result_valid, en_c} !== 2'b01) begin
            errors++; $display("FAIL %s pre_timeout: got rv/en_c=%b required 01", tag, {result_valid, en_c});
         end
         tick = 1'b1; cyc(1); tick = 1'b0;
         m_react = MAX_MS;
         m_timeout = 1'b1;
      end
      m_round++;
      m_sum += m_react;
      checks++;
      if ({result_valid, en_c, LED, timeout} !== {1'b1, 1'b0, {LED_W{1'b0}}, m_timeout}) begin
         errors++; $display("FAIL %s ctl: got rv=%b en_c=%b LED=%h to=%b required 1/0/0/%b",
                            tag, result_valid, en_c, LED, timeout, m_timeout);
      end
      checks++;
      if ({reaction_ms, best_ms, round_idx} !== {TIME_W'(m_react), TIME_W'(m_best), RW'(m_round)}) begin
         errors++; $display("FAIL %s regs: got react=%0d best=%0d round=%0d required %0d/%0d/%0d",
                            tag, reaction_ms, best_ms, round_idx, m_react, m_best, m_round);
      end
      start = 1'b1; cyc(1);
      checks++;
      if ({result_valid, done} !== {1'b0, m_round == ROUNDS}) begin
         errors++; $display("FAIL %s after: got rv=%b done=%b required 0/%b",
                            tag, result_valid, done, m_round == ROUNDS);
      end
`ifdef AVG_EN
      if (m_round < ROUNDS) begin
         checks++;
         if (avg_ms !== '0) begin
            errors++; $display("FAIL %s avg_early: got %0d required 0", tag, avg_ms);
         end
      end
`endif
   endtask

   task automatic test_final(input string tag);
      start = 1'b0; cyc(3);
      start = 1'b1; cyc(1);
      start = 1'b0; cyc(2);
      start = 1'b1; cyc(2);
      checks++;
      if ({done, en_dc, en_c, false_start, result_valid} !== 5'b10000) begin
         errors++; $display("FAIL %s ctl: got done/en_dc/en_c/fs/rv=%b required 10000",
                            tag, {done, en_dc, en_c, false_start, result_valid});
      end
      checks++;
      if ({reaction_ms, best_ms, round_idx, timeout} !==
          {TIME_W'(m_react), TIME_W'(m_best), RW'(m_round), m_timeout}) begin
         errors++; $display("FAIL %s hold: got react=%0d best=%0d round=%0d to=%b required %0d/%0d/%0d/%b",
                            tag, reaction_ms, best_ms, round_idx, timeout, m_react, m_best, m_round, m_timeout);
      end
`ifdef AVG_EN
      checks++;
      if (avg_ms !== TIME_W'(m_sum >> $clog2(ROUNDS))) begin
         errors++; $display("FAIL %s avg: got %0d required %0d", tag, avg_ms, m_sum >> $clog2(ROUNDS));
      end
`endif
   endtask

   task automatic test_first_round();
      go_arm(1'b0, "arm1");
      go_timing("timing1");
      react(7, "react1");
   endtask

   task automatic test_foul();
      go_arm(1'b0, "arm2");
      foul(m_dly - 2, "foul");
      go_arm(1'b1, "rearm");
      go_timing("timing2");
   endtask

   task automatic test_timeout();
      react(MAX_MS, "timeout");
   endtask

   task automatic test_reset_mid();
      test_reset("pre_mid", 1'b0);
      go_arm(1'b0, "mid_arm");
      go_timing("mid_timing");
      repeat (3) pulse_tick();
      test_reset("reset_mid", 1'b1);
      cyc(4);
      checks++;
      if ({en_dc, en_c, result_valid, LED} !== '0) begin
         errors++; $display("FAIL held_no_retrigger: got en_dc=%b en_c=%b rv=%b LED=%h required all zero",
                            en_dc, en_c, result_valid, LED);
      end
      start = 1'b1; cyc(1);
      go_arm(1'b0, "after_release");
      go_timing("after_release_t");
      react(3, "after_release_r");
   endtask

   task automatic test_random_games();
      int n, sel;
      for (int g = 0; g < 6; g++) begin
         test_reset("rnd_reset", 1'b0);
         for (int r = 0; r < ROUNDS; r++) begin
            go_arm(1'b0, "rnd_arm");
            if ($urandom_range(0, 2) == 0) begin
               foul(int'($urandom_range(0, m_dly - 1)), "rnd_foul");
               go_arm(1'b1, "rnd_rearm");
            end
            go_timing("rnd_timing");
            sel = int'($urandom_range(0, 3));
            case (sel)
               0:       n = MAX_MS;
               1:       n = 0;
               2:       n = MAX_MS - 1;
               default: n = int'($urandom_range(0, MAX_MS - 1));
            endcase
            react(n, "rnd_react");
         end
         test_final("rnd_final");
      end
   endtask

`ifdef AVG_EN
   task automatic test_avg();
      test_reset("avg_reset", 1'b0);
      go_arm(1'b0, "avg_arm1"); go_timing("avg_t1"); react(7, "avg_r1");
      go_arm(1'b0, "avg_arm2"); go_timing("avg_t2"); react(12, "avg_r2");
      checks++;
      if (avg_ms !== TIME_W'(9)) begin
         errors++; $display("FAIL avg_7_12: got %0d required 9", avg_ms);
      end
   endtask
`endif

   initial begin
      Reset = 1'b1; start = 1'b1; tick = 1'b0;
      cyc(2);
      test_reset("reset", 1'b0);
      test_first_round();
      test_foul();
      test_timeout();
      test_final("final");
      test_reset_mid();
      test_random_games();
`ifdef AVG_EN
      test_avg();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
